// File: rtl/inst_fetch_ctrl32.sv
// ---------------------------------------------------------------------------
// inst_fetch_ctrl32
//   Instruction fetch controller for the KLP32 core. Owns the program
//   counter, drives the combinational-read instruction memory address, and
//   buffers fetched words in a small prefetch FIFO that feeds decode over a
//   valid/ready handshake. PC redirects flush every buffered word except a
//   head accepted by decode in the same cycle.
//
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : a redirect to a non-word-aligned target raises fetch_fault
//               and stalls fetching until an aligned redirect or reset.
//   undefined : redirect targets are force-aligned; fetch_fault is tied low.
//
// Parameters
//   n         address / instruction width
//   RESET_PC  first fetch address after reset (4-byte aligned)
//   DEPTH     prefetch FIFO entries (power of two, >= 2)
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   fetch_en        allow new fetches; buffered entries drain regardless
//   mem_addr        address to inst_memory32 (equals the fetch PC)
//   mem_inst        word at mem_addr, valid combinationally
//   redirect_valid  one-cycle PC redirect request
//   redirect_pc     redirect target
//   out_valid       FIFO head valid
//   out_ready       decode accepts the head
//   out_inst        head instruction
//   out_pc          address of the head instruction
//   fetch_fault     misaligned-redirect fault
// ---------------------------------------------------------------------------
module inst_fetch_ctrl32 #(
  parameter int unsigned    n        = 32,
  parameter logic [n-1:0]   RESET_PC = '0,
  parameter int unsigned    DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fetch_en,
  output logic [n-1:0] mem_addr,
  input  logic [n-1:0] mem_inst,
  input  logic         redirect_valid,
  input  logic [n-1:0] redirect_pc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] out_inst,
  output logic [n-1:0] out_pc,
  output logic         fetch_fault
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  // Architectural state
  logic [n-1:0]     fetch_pc;
  logic [n-1:0]     pc_mem   [DEPTH];
  logic [n-1:0]     inst_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fault;

  // Next-state values
  logic [n-1:0]     fetch_pc_nxt;
  logic [PTR_W-1:0] wr_ptr_nxt;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic [n-1:0]     head_pc_nxt;
  logic [n-1:0]     head_inst_nxt;
  logic             valid_nxt;
  logic             push;
  logic             pop;

  // Target address a redirect loads into fetch_pc
  logic [n-1:0]     redirect_target;

  assign mem_addr = fetch_pc;

  // -------------------------------------------------------------------------
  // Misaligned-redirect handling
  // -------------------------------------------------------------------------
`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_nxt;

  // Target is taken unmodified; a non-zero low pair traps until realigned.
  always_comb begin
    redirect_target = redirect_pc;
    fault_nxt       = fault;
    if (redirect_valid) begin
      fault_nxt = |redirect_pc[1:0];
    end
  end

  // Fault flag register
  always_ff @(posedge clk) begin
    if (rst) begin
      fault <= 1'b0;
    end else begin
      fault <= fault_nxt;
    end
  end
`else
  // Low address bits are silently dropped; fault can never be raised.
  always_comb begin
    redirect_target = redirect_pc & ~n'(3);
  end

  assign fault = 1'b0;
`endif

  assign fetch_fault = fault;

  // -------------------------------------------------------------------------
  // Fetch / FIFO next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    fetch_pc_nxt  = fetch_pc;
    wr_ptr_nxt    = wr_ptr;
    rd_ptr_nxt    = rd_ptr;
    count_nxt     = count;
    head_pc_nxt   = '0;
    head_inst_nxt = '0;
    valid_nxt     = 1'b0;

    // A full FIFO never pushes, even when a pop frees a slot this cycle.
    push = fetch_en && (count < CNT_W'(DEPTH)) && !redirect_valid && !fault;
    pop  = out_valid && out_ready;

    if (redirect_valid) begin
      // Flush: a same-cycle accepted head has already been consumed by decode.
      fetch_pc_nxt = redirect_target;
      wr_ptr_nxt   = '0;
      rd_ptr_nxt   = '0;
      count_nxt    = '0;
    end else begin
      if (push) begin
        wr_ptr_nxt   = wr_ptr + PTR_W'(1);
        fetch_pc_nxt = fetch_pc + n'(4);
      end
      if (pop) begin
        rd_ptr_nxt = rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_nxt = count + CNT_W'(1);
        2'b01:   count_nxt = count - CNT_W'(1);
        default: count_nxt = count;
      endcase
    end

    // Registered head: the word being written this cycle becomes the head
    // whenever it lands on the slot the read pointer will point at.
    if (push && (wr_ptr == rd_ptr_nxt)) begin
      head_pc_nxt   = fetch_pc;
      head_inst_nxt = mem_inst;
    end else begin
      head_pc_nxt   = pc_mem[rd_ptr_nxt];
      head_inst_nxt = inst_mem[rd_ptr_nxt];
    end

    valid_nxt = (count_nxt != '0);
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc  <= RESET_PC;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_inst  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else begin
      fetch_pc  <= fetch_pc_nxt;
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      out_valid <= valid_nxt;
      out_pc    <= head_pc_nxt;
      out_inst  <= head_inst_nxt;
      if (push) begin
        pc_mem[wr_ptr]   <= fetch_pc;
        inst_mem[wr_ptr] <= mem_inst;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl32.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_ctrl32
//   Self-checking bench for inst_fetch_ctrl32. Two instances share the clock:
//   u_dut (RESET_PC=0) covers stream, backpressure, redirect, gating and
//   misaligned redirect; u_dut_wrap (RESET_PC=FFFF_FFF8) covers PC wrap.
//   Expected delivered PCs are queued as stimulus is driven and popped at
//   every out_valid && out_ready handshake.
// ---------------------------------------------------------------------------
module tb_inst_fetch_ctrl32;

  logic        clk;
  logic        rst;

  logic        fetch_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        fetch_fault;

  logic        fetch_en2;
  logic [31:0] mem_addr2;
  logic [31:0] mem_inst2;
  logic        redirect_valid2;
  logic [31:0] redirect_pc2;
  logic        out_valid2;
  logic        out_ready2;
  logic [31:0] out_inst2;
  logic [31:0] out_pc2;
  logic        fetch_fault2;

  int          total;
  int          bad;

  logic [31:0] q1 [$];
  logic [31:0] q2 [$];
  logic [31:0] exp1;
  logic [31:0] exp2;

  // Memory image: word i (address 4*i) holds 32'h1000_0000 + i
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign mem_inst  = word_at(mem_addr);
  assign mem_inst2 = word_at(mem_addr2);

  inst_fetch_ctrl32 #(.n(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .mem_addr       (mem_addr),
    .mem_inst       (mem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .fetch_fault    (fetch_fault)
  );

  inst_fetch_ctrl32 #(.n(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_dut_wrap (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en2),
    .mem_addr       (mem_addr2),
    .mem_inst       (mem_inst2),
    .redirect_valid (redirect_valid2),
    .redirect_pc    (redirect_pc2),
    .out_valid      (out_valid2),
    .out_ready      (out_ready2),
    .out_inst       (out_inst2),
    .out_pc         (out_pc2),
    .fetch_fault    (fetch_fault2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and direct checks happen 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for u_dut: compare every accepted head against the queue
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check_eq("sb1_has_entry", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        exp1 = q1.pop_front();
        check_eq("sb1_pc", out_pc, exp1);
        check_eq("sb1_inst", out_inst, word_at(exp1));
      end
    end
  end

  // Scoreboard for u_dut_wrap
  always @(negedge clk) begin
    if (!rst && out_valid2 && out_ready2) begin
      check_eq("sb2_has_entry", 32'(q2.size() != 0), 32'd1);
      if (q2.size() != 0) begin
        exp2 = q2.pop_front();
        check_eq("sb2_pc", out_pc2, exp2);
        check_eq("sb2_inst", out_inst2, word_at(exp2));
      end
    end
  end

  initial begin
    total           = 0;
    bad             = 0;
    rst             = 1'b1;
    fetch_en        = 1'b1;
    out_ready       = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    fetch_en2       = 1'b1;
    out_ready2      = 1'b1;
    redirect_valid2 = 1'b0;
    redirect_pc2    = '0;

    // Reset state
    step();
    step();
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_inst", out_inst, 32'd0);
    check_eq("rst_out_pc", out_pc, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_fetch_fault", 32'(fetch_fault), 32'd0);
    check_eq("rst_mem_addr_wrap", mem_addr2, 32'hFFFF_FFF8);

    // Release reset; expected stream up to the head taken in the redirect cycle
    rst = 1'b0;
    for (int i = 0; i < 6; i++) q1.push_back(32'(4 * i));
    q2.push_back(32'hFFFF_FFF8);
    q2.push_back(32'hFFFF_FFFC);
    q2.push_back(32'h0000_0000);
    q2.push_back(32'h0000_0004);
    check_eq("no_valid_before_edge", 32'(out_valid), 32'd0);

    step(); // t=1
    check_eq("first_valid", 32'(out_valid), 32'd1);
    check_eq("first_pc", out_pc, 32'd0);
    check_eq("first_inst", out_inst, 32'h1000_0000);
    check_eq("wrap_first_pc", out_pc2, 32'hFFFF_FFF8);

    step(); // t=2
    check_eq("wrap_mem_addr_zero", mem_addr2, 32'd0);
    check_eq("stream_pc_t2", out_pc, 32'd4);

    step(); // t=3
    check_eq("wrap_mem_addr_four", mem_addr2, 32'd4);
    out_ready = 1'b0;

    step(); // t=4
    fetch_en2 = 1'b0;

    step(); // t=5
    check_eq("bp_valid", 32'(out_valid), 32'd1);
    check_eq("bp_pc", out_pc, 32'd8);
    check_eq("bp_mem_addr", mem_addr, 32'd16);
    step();
    step();
    step(); // t=8
    check_eq("bp_pc_stable", out_pc, 32'd8);
    check_eq("bp_mem_addr_hold", mem_addr, 32'd16);
    out_ready = 1'b1;

    step();
    step();
    step(); // t=11, head 20
    out_ready = 1'b0;
    step(); // t=12, two entries buffered
    check_eq("pre_redir_mem_addr", mem_addr, 32'd28);

    // Redirect with a full FIFO; head 20 is accepted in the same cycle
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    out_ready      = 1'b1;
    q1.push_back(32'h0000_0100);
    q1.push_back(32'h0000_0104);
    q1.push_back(32'h0000_0108);
    q1.push_back(32'h0000_010C);
    step(); // t=13
    redirect_valid = 1'b0;
    check_eq("redir_bubble", 32'(out_valid), 32'd0);
    check_eq("redir_mem_addr", mem_addr, 32'h0000_0100);
    step(); // t=14
    check_eq("redir_valid", 32'(out_valid), 32'd1);
    check_eq("redir_pc", out_pc, 32'h0000_0100);
    step(); // t=15

    // Fetch gating
    fetch_en = 1'b0;
    step(); // t=16
    check_eq("gate_drained", 32'(out_valid), 32'd0);
    check_eq("gate_mem_addr", mem_addr, 32'h0000_0108);
    step();
    step(); // t=18
    check_eq("gate_hold_valid", 32'(out_valid), 32'd0);
    check_eq("gate_hold_addr", mem_addr, 32'h0000_0108);
    fetch_en = 1'b1;
    step(); // t=19
    check_eq("gate_resume_pc", out_pc, 32'h0000_0108);
    step(); // t=20, head 0x10C

    // Misaligned redirect
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
`ifdef FETCH_MISALIGN_TRAP_EN
    step(); // t=21
    redirect_valid = 1'b0;
    check_eq("mis_fault_set", 32'(fetch_fault), 32'd1);
    check_eq("mis_valid", 32'(out_valid), 32'd0);
    check_eq("mis_mem_addr", mem_addr, 32'h0000_0102);
    step(); // t=22
    check_eq("mis_fault_hold", 32'(fetch_fault), 32'd1);
    check_eq("mis_valid_hold", 32'(out_valid), 32'd0);
    check_eq("mis_addr_hold", mem_addr, 32'h0000_0102);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    q1.push_back(32'h0000_0200);
    step(); // t=23
    redirect_valid = 1'b0;
    check_eq("realign_fault_clr", 32'(fetch_fault), 32'd0);
    check_eq("realign_bubble", 32'(out_valid), 32'd0);
    check_eq("realign_mem_addr", mem_addr, 32'h0000_0200);
    step(); // t=24
    check_eq("realign_valid", 32'(out_valid), 32'd1);
    check_eq("realign_pc", out_pc, 32'h0000_0200);
    fetch_en = 1'b0;
`else
    q1.push_back(32'h0000_0100);
    step(); // t=21
    redirect_valid = 1'b0;
    check_eq("mis_no_fault", 32'(fetch_fault), 32'd0);
    check_eq("mis_bubble", 32'(out_valid), 32'd0);
    check_eq("mis_mem_addr", mem_addr, 32'h0000_0100);
    step(); // t=22
    check_eq("mis_valid", 32'(out_valid), 32'd1);
    check_eq("mis_pc", out_pc, 32'h0000_0100);
    check_eq("mis_no_fault_hold", 32'(fetch_fault), 32'd0);
    fetch_en = 1'b0;
`endif

    // Drain and confirm every expected word was delivered exactly once
    step();
    step();
    step();
    check_eq("end_valid", 32'(out_valid), 32'd0);
    check_eq("end_valid_wrap", 32'(out_valid2), 32'd0);
    check_eq("sb1_all_delivered", 32'(q1.size()), 32'd0);
    check_eq("sb2_all_delivered", 32'(q2.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl32.md
# inst_fetch_ctrl32

Instruction fetch controller for the KLP32 core. It owns the program counter, drives the combinational-read `inst_memory32` address port, and buffers fetched words in a small prefetch FIFO. It hands instructions to decode over a valid/ready handshake and accepts PC redirects from the branch/jump unit, flushing stale prefetched words.

## Interface
- `n`, 32: address/instruction width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; must be 4-byte aligned.
- `DEPTH`, 2: prefetch FIFO entries; power of two, ≥2.
- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `fetch_en` input 1: when low, no new fetches are pushed. Buffered entries still drain.
- `mem_addr` output n: address to `inst_memory32`. Always equals internal `fetch_pc`.
- `mem_inst` input n: word at `mem_addr`, valid combinationally in the same cycle.
- `redirect_valid` input 1: one-cycle PC redirect request.
- `redirect_pc` input n: redirect target.
- `out_valid` output 1: FIFO head is valid.
- `out_ready` input 1: decode accepts the head.
- `out_inst` output n: head instruction.
- `out_pc` output n: address of the head instruction.
- `fetch_fault` output 1: misaligned-redirect fault; see Configuration.

## Operation
- **State:**
  - `fetch_pc` (n bits).
  - FIFO of `DEPTH` entries {pc, inst}, with read and write pointers.
  - `count` (0..DEPTH).
  - `fault` flag.
- **Reset:** `fetch_pc`=RESET_PC, `count`=0, pointers=0, all entries cleared, `fault`=0.
  - Resulting outputs: `out_valid`=0, `out_inst`=0, `out_pc`=0, `mem_addr`=RESET_PC, `fetch_fault`=0.
- **Push condition:** `fetch_en` && `count`<DEPTH && !`redirect_valid` && !`fault`.
  - Push writes {`fetch_pc`, `mem_inst`} at the write pointer.
  - Then `fetch_pc` += 4, wrapping modulo 2^n (32'hFFFF_FFFC → 0).
- **Pop condition:** `out_valid` && `out_ready`. Advances the read pointer.
- **Simultaneous push and pop:** `count` is unchanged.
- **Full FIFO:** no push, even if a pop occurs in the same cycle. With DEPTH=2 and `out_ready` held high, steady state is `count`=1 and one instruction per cycle.
- **Outputs:** `out_valid` = (`count`≠0). `out_inst`/`out_pc` are the registered head entry.
- **Redirect:** `redirect_valid` has priority over push and pop.
  - `count`←0 and both pointers←0, so all buffered entries are discarded.
  - `fetch_pc`←`redirect_pc`, subject to Configuration.
  - A head accepted in the same cycle (`out_valid`&&`out_ready`) is still delivered to decode. Only the remaining entries are discarded.
- **`fetch_en` low mid-stream:** `fetch_pc` holds and the FIFO drains normally. Fetching resumes at the held PC when `fetch_en` rises.
- **Reset mid-operation:** reset overrides redirect, push and pop in the same cycle.

## Timing
- Fetch latency: a word pushed at edge k appears on `out_valid`/`out_inst` after edge k. That is one cycle after `mem_addr` presents its address.
- After reset release, the first `out_valid` is 1 cycle later (push at the first non-reset edge).
- Redirect penalty:
  - Redirect sampled at edge k.
  - `mem_addr`=target after k.
  - Target pushed at k+1; `out_valid` with `out_pc`=target after k+1.
  - `out_valid`=0 for exactly the cycle between k and k+1.
- No combinational path from `out_ready` or `redirect_*` to `out_*`. The only combinational path in this block is `mem_inst` → FIFO write data.

## Configuration
- **With `FETCH_MISALIGN_TRAP_EN` defined:**
  - A redirect with `redirect_pc[1:0]`≠0 sets `fault` and loads `fetch_pc`=`redirect_pc` unmodified.
  - While `fault`=1, `fetch_fault`=1 and no pushes occur; `out_valid` stays 0 after the flush.
  - An aligned redirect or reset clears `fault`. An aligned redirect then resumes fetching per normal redirect timing.
- **Without the macro:**
  - `redirect_pc[1:0]` is forced to 2'b00 when loaded.
  - `fault` never sets and `fetch_fault` is tied to 0.

## Test plan
- **Reset and sequential stream:** RESET_PC=0, memory word i = 32'h1000_0000+i, `out_ready`=1, `fetch_en`=1 → `out_pc` 0,4,8,… on consecutive cycles with matching `out_inst`. First `out_valid` is 1 cycle after reset release.
- **Backpressure:** `out_ready`=0 for 5 cycles → `count` saturates at 2, `mem_addr` holds at head_pc+8, and `out_pc` is stable. On release, no word is skipped or duplicated.
- **Redirect flush:** redirect to 32'h0000_0100 while 2 entries are buffered → one bubble cycle, then `out_pc`=0x100, 0x104. Stale entries never appear. A head accepted in the redirect cycle is counted as delivered.
- **PC wrap:** RESET_PC=32'hFFFF_FFF8 → `out_pc` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- **Fetch gating:** drop `fetch_en` for 3 cycles mid-stream → FIFO drains to empty and `mem_addr` holds. On re-enable, the stream resumes at the next sequential PC.
- **Misaligned redirect:** redirect to 32'h0000_0102.
  - With the macro: `fetch_fault`=1 and `out_valid`=0 until an aligned redirect to 0x200, then `out_pc`=0x200.
  - Without the macro: `out_pc`=0x100 and `fetch_fault`=0.
